// File: rtl/rv32_mem_store_unit.sv
// MEM-stage store engine: turns SB/SH/SW into word-aligned, byte-enabled write
// requests on the data-memory or IO port (addr[31] selects IO) with ack timeout.
module rv32_mem_store_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic        store_valid_in,
  output logic        memif_req,
  output logic [31:0] memif_addr,
  output logic [31:0] memif_wdata,
  output logic [3:0]  memif_be,
  input  logic        memif_ack,
  output logic        io_req,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  input  logic        io_ack,
  output logic        stall_out,
  output logic        store_done,
  output logic        misaligned_exc,
  output logic        bus_err,
  output logic [31:0] exc_pc
);

  typedef enum logic [1:0] {IDLE, MEM_REQ, IO_REQ} state_t;

  state_t             state_reg;
  logic [TMO_W-1:0]   cnt_reg;
  logic [31:0]        pc_reg;

  logic [1:0]         size;
  logic [1:0]         lo;
  logic               misaligned;
  logic [3:0]         be_next;
  logic [31:0]        wdata_next;
  logic [31:0]        addr_next;
  logic               active_ack;
  logic               timeout;
  logic               unused_iw;

  assign size      = iw_in[13:12];
  assign lo        = alu_result_in[1:0];
  assign addr_next = {alu_result_in[31:2], 2'b00};
  assign unused_iw = ^{iw_in[31:14], iw_in[11:0]};

  assign misaligned = (size == 2'd3) ||
                      (size == 2'd1 && lo[0]) ||
                      (size == 2'd2 && lo != 2'd0);

  // Per-lane byte enable and replicated write data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be_next[gi] = (size == 2'd0) ? (lo == 2'(gi)) :
                           (size == 2'd1) ? (lo[1] == 1'(gi / 2)) : 1'b1;
      assign wdata_next[8*gi +: 8] = (size == 2'd0) ? rs2_data_in[7:0] :
                                     (size == 2'd1) ? rs2_data_in[8*(gi%2) +: 8] :
                                                      rs2_data_in[8*gi +: 8];
    end
  endgenerate

  assign active_ack = (state_reg == MEM_REQ && memif_ack) ||
                      (state_reg == IO_REQ  && io_ack);
  assign timeout    = (state_reg != IDLE) && (cnt_reg == TMO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    stall_out = 1'b0;
    if (state_reg == IDLE)
      stall_out = store_valid_in && !misaligned;
    else
      stall_out = !active_ack && !timeout;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pc_reg         <= '0;
      memif_req      <= 1'b0;
      memif_addr     <= '0;
      memif_wdata    <= '0;
      memif_be       <= '0;
      io_req         <= 1'b0;
      io_addr        <= '0;
      io_wdata       <= '0;
      io_be          <= '0;
      store_done     <= 1'b0;
      misaligned_exc <= 1'b0;
      bus_err        <= 1'b0;
      exc_pc         <= '0;
    end else begin
      store_done     <= 1'b0;
      misaligned_exc <= 1'b0;
      bus_err        <= 1'b0;
      exc_pc         <= '0;
      case (state_reg)
        IDLE: begin
          if (store_valid_in) begin
            if (misaligned) begin
              misaligned_exc <= 1'b1;
              exc_pc         <= pc_in;
            end else begin
              pc_reg  <= pc_in;
              cnt_reg <= '0;
              if (alu_result_in[31]) begin
                io_req    <= 1'b1;
                io_addr   <= addr_next;
                io_wdata  <= wdata_next;
                io_be     <= be_next;
                state_reg <= IO_REQ;
              end else begin
                memif_req   <= 1'b1;
                memif_addr  <= addr_next;
                memif_wdata <= wdata_next;
                memif_be    <= be_next;
                state_reg   <= MEM_REQ;
              end
            end
          end
        end
        MEM_REQ, IO_REQ: begin
          if (active_ack || timeout) begin
            // Ack wins over a simultaneous timeout.
            memif_req   <= 1'b0;
            memif_addr  <= '0;
            memif_wdata <= '0;
            memif_be    <= '0;
            io_req      <= 1'b0;
            io_addr     <= '0;
            io_wdata    <= '0;
            io_be       <= '0;
            state_reg   <= IDLE;
            if (active_ack) begin
              store_done <= 1'b1;
            end else begin
              bus_err <= 1'b1;
              exc_pc  <= pc_reg;
            end
          end else begin
            cnt_reg <= cnt_reg + TMO_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_store_unit.sv
// Scoreboard bench for rv32_mem_store_unit: directed stores push expected
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_rv32_mem_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = '0, iw_in = '0, alu_result_in = '0, rs2_data_in = '0;
  logic        store_valid_in = 1'b0;
  logic        memif_req, io_req, memif_ack = 1'b0, io_ack = 1'b0;
  logic [31:0] memif_addr, memif_wdata, io_addr, io_wdata, exc_pc;
  logic [3:0]  memif_be, io_be;
  logic        stall_out, store_done, misaligned_exc, bus_err;

  rv32_mem_store_unit #(.ACK_TIMEOUT(16), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .iw_in(iw_in),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .store_valid_in(store_valid_in),
    .memif_req(memif_req), .memif_addr(memif_addr), .memif_wdata(memif_wdata),
    .memif_be(memif_be), .memif_ack(memif_ack),
    .io_req(io_req), .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be),
    .io_ack(io_ack), .stall_out(stall_out), .store_done(store_done),
    .misaligned_exc(misaligned_exc), .bus_err(bus_err), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  localparam int EV_MEM = 0, EV_IO = 1, EV_DONE = 2, EV_MIS = 3, EV_BERR = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;
    logic [31:0] pc;
    int          stalls;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  mem_wait = 0;
  int  io_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int len);
    ev_t e;
    e = '{kind: kind, addr: addr, wdata: wdata, be: be, len: len, pc: 32'h0, stalls: 0};
    exp_q.push_back(e);
  endtask

  task automatic push_ev(input int kind, input logic [31:0] pc, input int stalls);
    ev_t e;
    e = '{kind: kind, addr: 32'h0, wdata: 32'h0, be: 4'h0, len: 0, pc: pc, stalls: stalls};
    exp_q.push_back(e);
  endtask

  // Ack responders: ack after a configurable number of wait cycles (-1 = never).
  initial begin
    int wc;
    wc = 0;
    forever begin
      @(posedge clk); #1;
      if (memif_req) begin
        memif_ack = (wc == mem_wait);
        wc++;
      end else begin
        memif_ack = 1'b0;
        wc = 0;
      end
    end
  end

  initial begin
    int wc;
    wc = 0;
    forever begin
      @(posedge clk); #1;
      if (io_req) begin
        io_ack = (wc == io_wait);
        wc++;
      end else begin
        io_ack = 1'b0;
        wc = 0;
      end
    end
  end

  // Monitor
  initial begin
    logic        rst_prev, active, act_io;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    int          len, stall_cnt, unstable;
    ev_t         e;
    rst_prev = 1'b0; active = 1'b0; act_io = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0;
    len = 0; stall_cnt = 0; unstable = 0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        chk("reset_outputs", {29'd0, memif_req, io_req, stall_out}, 32'd0);
        chk("reset_pulses", {28'd0, store_done, misaligned_exc, bus_err, 1'b0}, 32'd0);
        chk("reset_data", memif_addr | memif_wdata | io_addr | io_wdata | exc_pc |
                          {24'd0, memif_be, io_be}, 32'd0);
      end
      if (memif_req)
        chk("io_idle_while_mem", {io_req, 3'd0, io_be} | io_addr | io_wdata, 32'd0);
      if (io_req)
        chk("mem_idle_while_io", {memif_req, 3'd0, memif_be} | memif_addr | memif_wdata, 32'd0);

      if ((memif_req || io_req) && !active) begin
        active = 1'b1; act_io = io_req; len = 1; unstable = 0;
        cap_addr  = io_req ? io_addr  : memif_addr;
        cap_wdata = io_req ? io_wdata : memif_wdata;
        cap_be    = io_req ? io_be    : memif_be;
      end else if ((memif_req || io_req) && active) begin
        len++;
        if ((act_io ? {io_addr, io_wdata, io_be} : {memif_addr, memif_wdata, memif_be})
            !== {cap_addr, cap_wdata, cap_be})
          unstable++;
      end else if (active) begin
        active = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("txn req  io=%0d addr=%h wdata=%h be=%b len=%0d", act_io, cap_addr, cap_wdata, cap_be, len);
          chk("req_iface", {31'd0, act_io}, (e.kind == EV_IO) ? 32'd1 : 32'd0);
          chk("req_addr", cap_addr, e.addr);
          chk("req_wdata", cap_wdata, e.wdata);
          chk("req_be", {28'd0, cap_be}, {28'd0, e.be});
          chk("req_len", len, e.len);
          chk("req_stable", unstable, 32'd0);
        end
      end

      if (store_done || misaligned_exc || bus_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {29'd0, store_done, misaligned_exc, bus_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("txn evt  done=%0d mis=%0d berr=%0d exc_pc=%h stalls=%0d",
                   store_done, misaligned_exc, bus_err, exc_pc, stall_cnt);
          chk("evt_pulses", {29'd0, store_done, misaligned_exc, bus_err},
              (e.kind == EV_DONE) ? 32'd4 : (e.kind == EV_MIS) ? 32'd2 : 32'd1);
          if (e.kind != EV_DONE) chk("evt_exc_pc", exc_pc, e.pc);
          chk("evt_stalls", stall_cnt, e.stalls);
        end
        stall_cnt = 0;
      end
      if (stall_out === 1'b1) stall_cnt++;
      if (!reset) stall_cnt = 0;
      rst_prev = !reset;
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    int n;
    pc_in = pc; iw_in = {17'd0, f3, 5'd0, 7'b0100011};
    alu_result_in = addr; rs2_data_in = data; store_valid_in = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_out) break;
      n++;
      if (n > 100) begin
        chk("stall_release_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    store_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int w;
    idle(3);
    reset = 1'b1;
    idle(2);

    // SB, byte lane 3, zero-wait ack
    mem_wait = 0;
    push_req(EV_MEM, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 1);
    push_ev(EV_DONE, 32'h0, 1);
    issue(32'h0000_0100, 3'd0, 32'h0000_1003, 32'h1234_56AB);
    idle(2);

    // SH to IO, upper half, 3 wait cycles
    io_wait = 3;
    push_req(EV_IO, 32'h8000_0010, 32'hBEEF_BEEF, 4'b1100, 4);
    push_ev(EV_DONE, 32'h0, 4);
    issue(32'h0000_0104, 3'd1, 32'h8000_0012, 32'h0000_BEEF);
    idle(2);

    // Misaligned SW
    push_ev(EV_MIS, 32'h0000_0040, 0);
    issue(32'h0000_0040, 3'd2, 32'h0000_2002, 32'h1111_1111);
    idle(2);

    // SB lane 1, SH lower half with funct3[2] set
    push_req(EV_MEM, 32'h0000_1000, 32'h5A5A_5A5A, 4'b0010, 1);
    push_ev(EV_DONE, 32'h0, 1);
    issue(32'h0000_0108, 3'd0, 32'h0000_1001, 32'hFFFF_FF5A);
    idle(1);
    push_req(EV_MEM, 32'h0000_1000, 32'h5678_5678, 4'b0011, 1);
    push_ev(EV_DONE, 32'h0, 1);
    issue(32'h0000_010C, 3'd5, 32'h0000_1000, 32'h1234_5678);
    idle(1);

    // Illegal width and misaligned SH
    push_ev(EV_MIS, 32'h0000_0110, 0);
    issue(32'h0000_0110, 3'd3, 32'h0000_1000, 32'h0);
    push_ev(EV_MIS, 32'h0000_0114, 0);
    issue(32'h0000_0114, 3'd1, 32'h0000_1001, 32'h0);
    idle(2);

    // SW with no ack: timeout after 16 req cycles
    mem_wait = -1;
    push_req(EV_MEM, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 16);
    push_ev(EV_BERR, 32'h0000_0200, 16);
    issue(32'h0000_0200, 3'd2, 32'h0000_3000, 32'hCAFE_F00D);
    idle(2);

    // Back-to-back SW, zero-wait
    mem_wait = 0;
    push_req(EV_MEM, 32'h0000_4004, 32'h1122_3344, 4'b1111, 1);
    push_ev(EV_DONE, 32'h0, 1);
    push_req(EV_MEM, 32'h0000_4008, 32'h5566_7788, 4'b1111, 1);
    push_ev(EV_DONE, 32'h0, 1);
    issue(32'h0000_0300, 3'd2, 32'h0000_4004, 32'h1122_3344);
    issue(32'h0000_0304, 3'd2, 32'h0000_4008, 32'h5566_7788);
    idle(3);

    // Reset on the second cycle of a waiting MEM_REQ
    mem_wait = -1;
    push_req(EV_MEM, 32'h0000_5000, 32'h0BAD_F00D, 4'b1111, 2);
    pc_in = 32'h0000_0400; iw_in = {17'd0, 3'd2, 5'd0, 7'b0100011};
    alu_result_in = 32'h0000_5000; rs2_data_in = 32'h0BAD_F00D; store_valid_in = 1'b1;
    idle(2);
    reset = 1'b0; store_valid_in = 1'b0;
    idle(1);
    reset = 1'b1;
    mem_wait = 0;
    idle(4);

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin idle(1); w++; end
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_mem_store_unit.md
Name: rv32_mem_store_unit

Overview:
- MEM-stage store engine: the write-direction counterpart to the WB-stage load-data extractor.
- Takes SB/SH/SW from the EX/MEM pipeline register and turns them into word-aligned write transactions with byte enables and lane-replicated write data.
- Drives either the data-memory interface or the IO interface (address bit 31 selects IO) over a req/ack handshake.
- Stalls the pipeline while a store is outstanding. Reports misaligned stores and ack timeouts.

Parameters:
- ACK_TIMEOUT, 16, number of cycles req may stay high without ack before the transaction is aborted as a bus error (legal range 2..255).
- TMO_W, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pc_in  in  32  PC of the instruction in MEM
- iw_in  in  32  instruction word; funct3 = iw_in[14:12]
- alu_result_in  in  32  effective store address
- rs2_data_in  in  32  store source data
- store_valid_in  in  1  instruction in MEM is a store
- memif_req  out  1  data-memory write request
- memif_addr  out  32  word address, {addr[31:2],2'b00}
- memif_wdata  out  32  lane-replicated write data
- memif_be  out  4  byte enables
- memif_ack  in  1  data-memory completion
- io_req, io_addr, io_wdata, io_be  out  1/32/32/4  IO equivalents of the memif_* outputs
- io_ack  in  1  IO completion
- stall_out  out  1  hold IF..MEM pipeline registers
- store_done  out  1  one-cycle pulse when a store completes
- misaligned_exc  out  1  one-cycle pulse for a misaligned or illegal store
- bus_err  out  1  one-cycle pulse on ack timeout
- exc_pc  out  32  PC of the store that raised misaligned_exc or bus_err

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0 and the counter clears.
  - Reset during MEM_REQ/IO_REQ drops req on the next edge, with no store_done and no bus_err.
- Width decode (funct3[1:0]):
  - 0 = SB: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - 1 = SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - 2 = SW: be = 4'b1111; wdata = rs2.
  - funct3[2] is ignored for stores.
- Misaligned or illegal store: SH with addr[0]=1, SW with addr[1:0]!=0, or funct3[1:0]=3.
- States: IDLE, MEM_REQ, IO_REQ.
- In IDLE with store_valid_in=1 and an aligned store:
  - Register addr, wdata and be into the selected interface.
  - Go to IO_REQ if addr[31]=1, otherwise MEM_REQ.
  - req rises on the next cycle; the other interface's outputs stay 0.
- In IDLE with store_valid_in=1 and a misaligned store:
  - No request is issued and the state stays IDLE.
  - Next cycle: misaligned_exc=1 and exc_pc=pc_in for one cycle.
- In MEM_REQ/IO_REQ:
  - addr, wdata and be are held stable while req=1.
  - An ack with req=1 completes the transaction: next edge req=0, store_done=1 for one cycle, state returns to IDLE.
  - ack is sampled only from the active interface; ack in IDLE is ignored.
- Timeout:
  - The counter clears on entry to a REQ state and increments each REQ cycle without ack.
  - When the counter reaches ACK_TIMEOUT-1 without ack: next edge req=0, bus_err=1 for one cycle, exc_pc = latched PC, state returns to IDLE.
  - ack arriving in that same cycle takes priority and the store completes normally.
- stall_out (combinational):
  - 1 when IDLE && store_valid_in && aligned.
  - 1 when in a REQ state with no ack and no timeout that cycle.
  - 0 otherwise, so the pipeline advances in the ack cycle and the timeout cycle.
  - A store therefore stalls for a minimum of 1 cycle (zero-wait ack).
- Back-to-back stores: the next store is accepted in IDLE on the cycle after completion. There is no bubble beyond that.
- Outputs drop to 0 when the interface is idle (req=0); they are not held.
- Loads and non-memory instructions (store_valid_in=0) produce no activity.

Test Plan:
- SB, addr 0x0000_1003, rs2 0x1234_56AB, zero-wait memif_ack → memif_addr 0x0000_1000, be 4'b1000, wdata 0xABAB_ABAB; stall_out high 1 cycle, then store_done pulse.
- SH, addr 0x8000_0012, rs2 0x0000_BEEF, io_ack after 3 wait cycles → io_req high 4 cycles, io_be 4'b1100, io_wdata 0xBEEF_BEEF; memif_req stays 0; stall_out high 4 cycles.
- SW, addr 0x0000_2002, pc 0x0000_0040 → no req; misaligned_exc 1 cycle later with exc_pc 0x0000_0040; stall_out never asserted.
- SW, addr 0x0000_3000, memif_ack never asserted, ACK_TIMEOUT=16 → req high exactly 16 cycles, then bus_err pulse with exc_pc = store PC, state back in IDLE.
- Two consecutive SW with zero-wait ack → two memif_req pulses separated by one idle cycle, two store_done pulses, correct data per store.
- reset=0 asserted on the second cycle of a waiting MEM_REQ → memif_req 0 the next cycle, all outputs 0, no store_done and no bus_err.
